// File: rtl/baby_pkg.sv
// Shared constants for the Manchester Baby store: command opcodes,
// control sub-codes, FSM state encoding and default geometry.
package baby_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Command byte opcode field, bits [7:6]
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CTRL  = 2'b11;

  // Control sub-code field, bits [1:0] of an OP_CTRL byte (2'b11 is ignored)
  localparam logic [1:0] CTRL_HALT   = 2'b00;
  localparam logic [1:0] CTRL_RUN    = 2'b01;
  localparam logic [1:0] CTRL_STATUS = 2'b10;

  // Host-side FSM states; the enum names the encoding, the localparams are
  // what the RTL compares against.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_DATA = 2'd1,
    S_RD_SEND = 2'd2,
    S_ST_SEND = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE    = S_IDLE;
  localparam logic [1:0] ST_WR_DATA = S_WR_DATA;
  localparam logic [1:0] ST_RD_SEND = S_RD_SEND;
  localparam logic [1:0] ST_ST_SEND = S_ST_SEND;

endpackage

// File: rtl/baby_store_if.sv
// Core RAM port plus byte-wide host channel of the Baby store.
// Handshake rule (both directions): a byte moves at a rising clock edge
// where valid and ready are both 1; the sender holds the byte stable while
// valid is 1 and the byte has not yet moved.
interface baby_store_if #(
  parameter int ADDR_W = baby_pkg::ADDR_W_DEF,
  parameter int DATA_W = baby_pkg::DATA_W_DEF
);
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_data_i;
  logic [DATA_W-1:0] cpu_data_o;
  logic              cpu_rw_en_i;
  logic              cpu_stop_i;
  logic              cpu_reset_o;
  logic [7:0]        host_byte_i;
  logic              host_valid_i;
  logic              host_ready_o;
  logic [7:0]        host_byte_o;
  logic              host_valid_o;
  logic              host_ready_i;
  logic [1:0]        fsm_state;     // debug view of the host FSM

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_rw_en_i, cpu_stop_i,
           host_byte_i, host_valid_i, host_ready_i,
    output cpu_data_o, cpu_reset_o, host_ready_o, host_byte_o,
           host_valid_o, fsm_state
  );

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_rw_en_i, cpu_stop_i,
           host_byte_i, host_valid_i, host_ready_i,
    input  cpu_data_o, cpu_reset_o, host_ready_o, host_byte_o,
           host_valid_o, fsm_state
  );
endinterface

// File: rtl/baby_store_array.sv
// Register array with async clear: one write port, two combinational
// read ports (core and host snapshot).
module baby_store_array
  import baby_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear every word on reset, otherwise commit the single write port
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/baby_store.sv
// Baby store top: 2**ADDR_W x DATA_W memory shared between the core's RAM
// port and a byte-serial host load/readback channel. Whenever the host
// touches the store the core is held in reset until an explicit RUN.
module baby_store
  import baby_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic         clock,
  input  logic         reset_i,
  baby_store_if.slave  bus
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] word_buf;   // assembles write words, shifts read words
  logic              cpu_reset;

  logic              accept;
  logic              take;
  logic [1:0]        opcode;
  logic [1:0]        ctrl;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] fill_word;
  logic [DATA_W-1:0] snap;
  logic              host_we;
  logic              core_we;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign accept   = bus.host_valid_i & bus.host_ready_o;
  assign take     = bus.host_valid_o & bus.host_ready_i;
  assign opcode   = bus.host_byte_i[7:6];
  assign ctrl     = bus.host_byte_i[1:0];
  assign cmd_addr = bus.host_byte_i[ADDR_W-1:0];

  assign bus.host_ready_o = (state == ST_IDLE) || (state == ST_WR_DATA);
  assign bus.host_valid_o = (state == ST_RD_SEND) || (state == ST_ST_SEND);
  assign bus.host_byte_o  = bus.host_valid_o ? word_buf[7:0] : 8'h00;
  assign bus.cpu_reset_o  = cpu_reset;
  assign bus.fsm_state    = state;

  // Current write word with the incoming byte dropped into lane cnt
  always_comb begin
    fill_word = word_buf;
    fill_word[int'(cnt) * 8 +: 8] = bus.host_byte_i;
  end

  // Write port mux: host writes only happen while the core is held, so the
  // two sources never collide. The core gate uses the pre-edge cpu_reset.
  always_comb begin
    host_we = (state == ST_WR_DATA) && accept && (cnt == LAST);
    core_we = bus.cpu_rw_en_i & ~cpu_reset;
    we      = host_we | core_we;
    waddr   = host_we ? addr : bus.cpu_addr_i;
    wdata   = host_we ? fill_word : bus.cpu_data_i;
  end

  baby_store_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clock   (clock),
    .reset_i (reset_i),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (bus.cpu_addr_i),
    .rdata_a (bus.cpu_data_o),
    .raddr_b (cmd_addr),
    .rdata_b (snap)
  );

  // Host command FSM: decode in IDLE, collect/send bytes LSB first
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      addr      <= '0;
      cnt       <= '0;
      word_buf  <= '0;
      cpu_reset <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (opcode)
              OP_WRITE: begin
                addr      <= cmd_addr;
                cnt       <= '0;
                word_buf  <= '0;
                cpu_reset <= 1'b1;
                state     <= ST_WR_DATA;
              end
              OP_READ: begin
                word_buf  <= snap;
                cnt       <= '0;
                cpu_reset <= 1'b1;
                state     <= ST_RD_SEND;
              end
              OP_CTRL: begin
                case (ctrl)
                  CTRL_HALT: cpu_reset <= 1'b1;
                  CTRL_RUN:  cpu_reset <= 1'b0;
                  CTRL_STATUS: begin
                    word_buf <= {{(DATA_W - 8){1'b0}}, ~cpu_reset,
                                 bus.cpu_stop_i, 6'b000000};
                    state    <= ST_ST_SEND;
                  end
                  default: ;
                endcase
              end
              default: ;
            endcase
          end
        end
        ST_WR_DATA: begin
          if (accept) begin
            word_buf <= fill_word;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST) state <= ST_IDLE;
          end
        end
        ST_RD_SEND: begin
          if (take) begin
            word_buf <= word_buf >> 8;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST) state <= ST_IDLE;
          end
        end
        ST_ST_SEND: begin
          if (take) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_baby_store.sv
// Directed bench for baby_store: table of host write/readback vectors plus
// hand-written sequences for handshake stalls, core/host interplay and
// mid-transaction reset.
module tb_baby_store;
  import baby_pkg::*;

  logic clock = 1'b0;
  logic reset_i = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];

  baby_store_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  baby_store dut (
    .clock   (clock),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  addr;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_word;
  } wvec_t;

  wvec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Offer one byte to the store and hold it until accepted (bounded)
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    bus.host_byte_i  = b;
    bus.host_valid_i = 1'b1;
    while (!bus.host_ready_o && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("send_ready", {31'd0, bus.host_ready_o}, 32'd1);
    @(posedge clock);
    #1;
    bus.host_valid_i = 1'b0;
  endtask

  // Take one response byte and compare it with the head of exp_q
  task automatic recv_check(input string name);
    int n = 0;
    logic [7:0] exp_b;
    @(negedge clock);
    bus.host_ready_i = 1'b1;
    while (!bus.host_valid_o && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({name, "_valid"}, {31'd0, bus.host_valid_o}, 32'd1);
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check(name, {24'd0, bus.host_byte_o}, {24'd0, exp_b});
    @(posedge clock);
    #1;
    bus.host_ready_i = 1'b0;
  endtask

  task automatic core_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.cpu_addr_i  = a;
    bus.cpu_data_i  = d;
    bus.cpu_rw_en_i = 1'b1;
    @(posedge clock);
    #1;
    bus.cpu_rw_en_i = 1'b0;
  endtask

  task automatic peek(input string name, input logic [4:0] a, input logic [31:0] exp);
    bus.cpu_addr_i = a;
    #1;
    check(name, bus.cpu_data_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int transfers;
    logic held_v;
    logic [7:0] held_b;
    logic rdy;

    vecs[0] = '{addr: 5'd0,  b0: 8'h01, b1: 8'h00, b2: 8'h00, b3: 8'h00, exp_word: 32'h0000_0001};
    vecs[1] = '{addr: 5'd31, b0: 8'hFF, b1: 8'hEE, b2: 8'hDD, b3: 8'hCC, exp_word: 32'hCCDD_EEFF};
    vecs[2] = '{addr: 5'd10, b0: 8'h80, b1: 8'h00, b2: 8'h00, b3: 8'h80, exp_word: 32'h8000_0080};
    vecs[3] = '{addr: 5'd1,  b0: 8'hC1, b1: 8'hC0, b2: 8'hC2, b3: 8'hC3, exp_word: 32'hC3C2_C0C1};
    vecs[4] = '{addr: 5'd2,  b0: 8'hAA, b1: 8'h55, b2: 8'hAA, b3: 8'h55, exp_word: 32'h55AA_55AA};

    bus.cpu_addr_i   = '0;
    bus.cpu_data_i   = '0;
    bus.cpu_rw_en_i  = 1'b0;
    bus.cpu_stop_i   = 1'b0;
    bus.host_byte_i  = '0;
    bus.host_valid_i = 1'b0;
    bus.host_ready_i = 1'b0;

    // ---- 1: reset state, STATUS, cleared array
    repeat (3) @(negedge clock);
    reset_i = 1'b0;
    #1;
    check("rst_cpu_reset", {31'd0, bus.cpu_reset_o}, 32'd1);
    check("rst_host_ready", {31'd0, bus.host_ready_o}, 32'd1);
    check("rst_host_valid", {31'd0, bus.host_valid_o}, 32'd0);
    check("rst_host_byte", {24'd0, bus.host_byte_o}, 32'd0);
    check("rst_state", {30'd0, bus.fsm_state}, 32'd0);
    for (int a = 0; a < 32; a++) peek("rst_mem", 5'(a), 32'd0);
    send_byte(8'h00);  // NOP
    check("nop_state", {30'd0, bus.fsm_state}, 32'd0);
    send_byte(8'hC2);
    exp_q.push_back(8'h00);
    recv_check("status_halted");

    // ---- 2: host WRITE word 5, visible on the core port, READ back
    bus.cpu_addr_i = 5'd5;
    send_byte(8'h45);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    #1;
    check("partial_not_written", bus.cpu_data_o, 32'd0);
    send_byte(8'h12);
    check("wr5_core_view", bus.cpu_data_o, 32'h1234_5678);
    send_byte(8'h85);
    exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    for (int i = 0; i < 4; i++) recv_check("rd5_byte");
    check("rd5_idle", {30'd0, bus.fsm_state}, 32'd0);

    // ---- table: host writes then readbacks across boundary addresses
    foreach (vecs[i]) begin
      bus.cpu_addr_i = vecs[i].addr;
      send_byte({3'b010, vecs[i].addr});
      send_byte(vecs[i].b0);
      send_byte(vecs[i].b1);
      send_byte(vecs[i].b2);
      send_byte(vecs[i].b3);
      check("vec_core_view", bus.cpu_data_o, vecs[i].exp_word);
      check("vec_still_held", {31'd0, bus.cpu_reset_o}, 32'd1);
    end
    foreach (vecs[i]) begin
      peek("vec_no_overwrite", vecs[i].addr, vecs[i].exp_word);
      send_byte({3'b100, vecs[i].addr});
      for (int k = 0; k < 4; k++) exp_q.push_back(vecs[i].exp_word[k*8 +: 8]);
      for (int k = 0; k < 4; k++) recv_check("vec_rd_byte");
    end
    peek("addr5_intact", 5'd5, 32'h1234_5678);

    // ---- 3: READ with host_ready_i pattern 1,0,0,1
    send_byte(8'h85);
    exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    transfers = 0;
    held_v = 1'b0;
    held_b = 8'h00;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      rdy = (c % 4 == 0) || (c % 4 == 3);
      bus.host_ready_i = rdy;
      if (bus.host_valid_o) begin
        if (held_v) check("stall_stable", {24'd0, bus.host_byte_o}, {24'd0, held_b});
        if (rdy) begin
          transfers++;
          if (exp_q.size() > 0)
            check("stall_byte", {24'd0, bus.host_byte_o}, {24'd0, exp_q.pop_front()});
          else
            check("stall_extra_byte", {24'd0, bus.host_byte_o}, 32'hFFFF_FFFF);
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_b = bus.host_byte_o;
        end
      end
    end
    bus.host_ready_i = 1'b0;
    check("stall_transfers", 32'(transfers), 32'd4);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // ---- 4: RUN, core write to 31, READ halts the core, STATUS with stop
    send_byte(8'hC1);
    check("run_released", {31'd0, bus.cpu_reset_o}, 32'd0);
    core_write(5'd31, 32'hDEAD_BEEF);
    peek("core_wr31", 5'd31, 32'hDEAD_BEEF);
    send_byte(8'h9F);
    check("read_halts_core", {31'd0, bus.cpu_reset_o}, 32'd1);
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    for (int i = 0; i < 4; i++) recv_check("rd31_byte");
    check("read_no_auto_run", {31'd0, bus.cpu_reset_o}, 32'd1);
    bus.cpu_stop_i = 1'b1;
    send_byte(8'hC1);
    send_byte(8'hC2);
    exp_q.push_back(8'hC0);
    recv_check("status_run_stop");
    bus.cpu_stop_i = 1'b0;

    // ---- 5: HALT on the same edge as a core write; next write ignored
    check("pre_halt_running", {31'd0, bus.cpu_reset_o}, 32'd0);
    @(negedge clock);
    check("halt_ready", {31'd0, bus.host_ready_o}, 32'd1);
    bus.host_byte_i  = 8'hC0;
    bus.host_valid_i = 1'b1;
    bus.cpu_addr_i   = 5'd3;
    bus.cpu_data_i   = 32'hA5A5_A5A5;
    bus.cpu_rw_en_i  = 1'b1;
    @(posedge clock);
    #1;
    bus.host_valid_i = 1'b0;
    bus.cpu_data_i   = 32'h1111_1111;
    check("halt_cpu_reset", {31'd0, bus.cpu_reset_o}, 32'd1);
    check("halt_same_edge_write", bus.cpu_data_o, 32'hA5A5_A5A5);
    @(posedge clock);
    #1;
    bus.cpu_rw_en_i = 1'b0;
    check("halted_write_ignored", bus.cpu_data_o, 32'hA5A5_A5A5);

    // ---- 6: partial WRITE to 7 aborted by reset
    bus.cpu_addr_i = 5'd7;
    send_byte(8'h47);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clock);
    #2 reset_i = 1'b1;
    #1;
    check("async_reset_state", {30'd0, bus.fsm_state}, 32'd0);
    @(negedge clock);
    reset_i = 1'b0;
    peek("abort_mem7", 5'd7, 32'd0);
    peek("abort_mem5_cleared", 5'd5, 32'd0);
    check("abort_cpu_reset", {31'd0, bus.cpu_reset_o}, 32'd1);
    check("abort_ready", {31'd0, bus.host_ready_o}, 32'd1);
    bus.cpu_addr_i = 5'd7;
    send_byte(8'h47);
    send_byte(8'h04);
    send_byte(8'h03);
    send_byte(8'h02);
    send_byte(8'h01);
    check("after_abort_write", bus.cpu_data_o, 32'h0102_0304);
    send_byte(8'hC2);
    exp_q.push_back(8'h00);
    recv_check("after_abort_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
